update_sweep_ctrl: RTL and testbench

//  Drives a LUTRAM update in the fractured-TCAM update logic.
//  On a start handshake it latches one rule (value + don't-care mask) split into NUM_CH chunks of ADDR_W bits.
//  It then sweeps a write address 0..2^ADDR_W-1, one address per cycle.
//  Per address it emits one write bit per chunk: 1 iff the chunk ternary-matches the address.

---
 rtl/fractcam_update_pkg.sv | 12 +
 rtl/ternary_chunk_cmp.sv | 15 +
 rtl/update_sweep_ctrl.sv | 102 ++++++++++
 tb/tb_update_sweep_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fractcam_update_pkg.sv
// fractcam_update_pkg: shared FSM encoding, default sizes and chunk slice helper for the TCAM update logic
package fractcam_update_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_CH = 4;
  localparam int MAX_BUS    = 256;
  function automatic logic [31:0] chunk_slice(input logic [MAX_BUS-1:0] bus, input int idx, input int w);
    return 32'(bus >> (idx * w));
  endfunction
endpackage

// File: rtl/ternary_chunk_cmp.sv
// ternary_chunk_cmp: one chunk matches the address when every non-masked bit agrees
//   i_value [ADDR_W]  chunk value
//   i_mask  [ADDR_W]  1 = don't-care bit
//   i_addr  [ADDR_W]  address under test
//   o_match           1 iff value and address agree on all cared-for bits
module ternary_chunk_cmp #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] i_value,
  input  logic [ADDR_W-1:0] i_mask,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_match
);
  assign o_match = ((i_value ^ i_addr) & ~i_mask) == '0;
endmodule

// File: rtl/update_sweep_ctrl.sv
// update_sweep_ctrl: sweeps every LUTRAM address and writes one ternary-match bit per rule chunk
//   clk, rst (sync, active-high)
//   start_valid/start_ready  start handshake; start_erase, rule_value, rule_mask sampled at accept
//   wr_en, wr_addr, wr_data  LUTRAM write port (one column per chunk)
//   busy                     sweep in progress incl. drain; done one-cycle pulse after final write
//   Macro UPDATE_SWEEP_PIPE_EN adds one output register stage on the write port and done.
module update_sweep_ctrl import fractcam_update_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic                     start_erase,
  input  logic [NUM_CH*ADDR_W-1:0] rule_value,
  input  logic [NUM_CH*ADDR_W-1:0] rule_mask,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [NUM_CH-1:0]        wr_data,
  output logic                     busy,
  output logic                     done
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  logic [1:0] r_state, w_state_nx;
  logic [ADDR_W-1:0] r_count, w_count_nx, r_wr_addr;
  logic [NUM_CH*ADDR_W-1:0] r_value, r_mask, w_value, w_mask;
  logic [NUM_CH-1:0] w_match, r_wr_data;
  logic r_erase, w_erase, w_accept, w_ready;
  assign w_accept   = start_valid & w_ready;
  assign w_state_nx = w_accept ? ST_SWEEP :
                      r_state == ST_SWEEP ? (r_count == LAST ? ST_FIN : ST_SWEEP) : ST_IDLE;
  assign w_count_nx = r_state == ST_SWEEP ? r_count + 1'b1 : '0;
  assign w_value    = w_accept ? rule_value : r_value;
  assign w_mask     = w_accept ? rule_mask : r_mask;
  assign w_erase    = w_accept ? start_erase : r_erase;
  // Compare against the next address and next rule so the write port is a plain register
  // that updates together with the FSM and holds while idle.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
    ternary_chunk_cmp #(.ADDR_W(ADDR_W)) u_cmp (
      .i_value(ADDR_W'(chunk_slice(MAX_BUS'(w_value), i, ADDR_W))),
      .i_mask (ADDR_W'(chunk_slice(MAX_BUS'(w_mask), i, ADDR_W))),
      .i_addr (w_count_nx),
      .o_match(w_match[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_value   <= '0;
      r_mask    <= '0;
      r_erase   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      if (w_accept) begin
        r_value <= rule_value;
        r_mask  <= rule_mask;
        r_erase <= start_erase;
      end
      if (w_state_nx == ST_SWEEP) begin
        r_wr_addr <= w_count_nx;
        r_wr_data <= w_match & ~{NUM_CH{w_erase}};
      end
    end
  end
`ifdef UPDATE_SWEEP_PIPE_EN
  logic r_p_en, r_p_done;
  logic [ADDR_W-1:0] r_p_addr;
  logic [NUM_CH-1:0] r_p_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_en   <= 1'b0;
      r_p_done <= 1'b0;
      r_p_addr <= '0;
      r_p_data <= '0;
    end else begin
      r_p_en   <= r_state == ST_SWEEP;
      r_p_done <= r_state == ST_FIN;
      r_p_addr <= r_wr_addr;
      r_p_data <= r_wr_data;
    end
  end
  // Hold off a new start while the last write is still in the stage, so ready rises with done.
  assign w_ready = (r_state != ST_SWEEP) & ~r_p_en;
  assign wr_en   = r_p_en;
  assign wr_addr = r_p_addr;
  assign wr_data = r_p_data;
  assign done    = r_p_done;
`else
  assign w_ready = r_state != ST_SWEEP;
  assign wr_en   = r_state == ST_SWEEP;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign done    = r_state == ST_FIN;
`endif
  assign start_ready = w_ready;
  assign busy        = ~w_ready;
endmodule

// File: tb/tb_update_sweep_ctrl.sv
// tb_update_sweep_ctrl: directed self-checking bench for update_sweep_ctrl (ADDR_W=5, NUM_CH=2)
module tb_update_sweep_ctrl;
`ifdef UPDATE_SWEEP_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0;
  logic start_ready;
  logic start_erase = 1'b0;
  logic [9:0] rule_value = '0;
  logic [9:0] rule_mask = '0;
  logic wr_en, busy, done;
  logic [4:0] wr_addr;
  logic [1:0] wr_data;
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_done = 0;
  logic [4:0] cap_addr [32];
  logic [1:0] cap_data [32];
  int cap_lat, cap_gaps, cap_done_pos, cap_next;
  update_sweep_ctrl #(.ADDR_W(5), .NUM_CH(2)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .start_erase(start_erase), .rule_value(rule_value), .rule_mask(rule_mask),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_en) n_wr <= n_wr + 1;
    if (done) n_done <= n_done + 1;
  end
  task automatic sweep(input logic [9:0] v, input logic [9:0] m, input logic e, input bit hold);
    start_valid = 1'b1;
    rule_value = v;
    rule_mask = m;
    start_erase = e;
    cap_gaps = 0;
    cap_done_pos = -1;
    cap_next = -1;
    @(negedge clk);
    if (!hold) begin
      start_valid = 1'b0;
      rule_value = ~v;
      rule_mask = '0;
      start_erase = ~e;
    end
    cap_lat = 1;
    while (!wr_en && cap_lat < 10) begin
      @(negedge clk);
      cap_lat++;
    end
    for (int i = 0; i < 32; i++) begin
      cap_addr[i] = wr_addr;
      cap_data[i] = wr_data;
      if (!wr_en) cap_gaps++;
      @(negedge clk);
    end
    for (int k = 1; k <= 4; k++) begin
      if (done && cap_done_pos < 0) cap_done_pos = k;
      if (wr_en && cap_next < 0) cap_next = k;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({start_ready, busy, wr_en, done, wr_addr, wr_data} !== {4'b1000, 5'd0, 2'd0}) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: got rdy/busy/en/done/addr/data=%b exp 10000000000", i,
                 {start_ready, busy, wr_en, done, wr_addr, wr_data});
      end
    end
  endtask
  task automatic test_exact;
    int d0;
    d0 = n_done;
    sweep({5'd7, 5'd3}, 10'd0, 1'b0, 1'b0);
    n_cmp++;
    if (cap_lat !== LAT) begin n_bad++; $display("FAIL exact_latency: got %0d exp %0d", cap_lat, LAT); end
    n_cmp++;
    if (cap_gaps !== 0) begin n_bad++; $display("FAIL exact_gaps: got %0d exp 0", cap_gaps); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap_addr[i] !== 5'(i)) begin n_bad++; $display("FAIL exact_addr[%0d]: got %0d exp %0d", i, cap_addr[i], i); end
      n_cmp++;
      if (cap_data[i] !== (i == 3 ? 2'b01 : i == 7 ? 2'b10 : 2'b00)) begin
        n_bad++;
        $display("FAIL exact_data at addr %0d: got %b exp %b", i, cap_data[i], (i == 3 ? 2'b01 : i == 7 ? 2'b10 : 2'b00));
      end
    end
    n_cmp++;
    if (cap_done_pos !== 1) begin n_bad++; $display("FAIL exact_done_pos: got %0d exp 1", cap_done_pos); end
    n_cmp++;
    if (n_done - d0 !== 1) begin n_bad++; $display("FAIL exact_done_count: got %0d exp 1", n_done - d0); end
    n_cmp++;
    if (cap_next !== -1) begin n_bad++; $display("FAIL exact_no_extra_write: got %0d exp -1", cap_next); end
  endtask
  task automatic test_mask;
    sweep({5'd9, 5'b10100}, {5'b11111, 5'b00011}, 1'b0, 1'b0);
    n_cmp++;
    if (cap_gaps !== 0) begin n_bad++; $display("FAIL mask_gaps: got %0d exp 0", cap_gaps); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap_data[i] !== {1'b1, i >= 20 && i <= 23}) begin
        n_bad++;
        $display("FAIL mask_data at addr %0d: got %b exp %b", i, cap_data[i], {1'b1, i >= 20 && i <= 23});
      end
    end
  endtask
  task automatic test_back_to_back;
    int w0, d0, t;
    w0 = n_wr;
    d0 = n_done;
    sweep({5'd7, 5'd3}, 10'd0, 1'b1, 1'b1);
    start_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap_data[i] !== 2'b00) begin n_bad++; $display("FAIL erase_data at addr %0d: got %b exp 00", i, cap_data[i]); end
    end
    n_cmp++;
    if (cap_next !== 1 + LAT) begin n_bad++; $display("FAIL b2b_restart_pos: got %0d exp %0d", cap_next, 1 + LAT); end
    t = 0;
    while (!(start_ready && !wr_en && !done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_cmp++;
    if (t >= 100) begin n_bad++; $display("FAIL b2b_timeout: got %0d cycles exp <100", t); end
    n_cmp++;
    if (n_wr - w0 !== 64) begin n_bad++; $display("FAIL b2b_write_count: got %0d exp 64", n_wr - w0); end
    n_cmp++;
    if (n_done - d0 !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d exp 2", n_done - d0); end
  endtask
  task automatic test_rst_mid;
    int t, d0;
    start_valid = 1'b1;
    rule_value = {5'd7, 5'd3};
    rule_mask = '0;
    start_erase = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    t = 0;
    while (!(wr_en && wr_addr == 5'd10) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 20) begin n_bad++; $display("FAIL rst_mid_reach_addr10: got %0d cycles exp <20", t); end
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({start_ready, busy, wr_en, done, wr_addr, wr_data} !== {4'b1000, 5'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got rdy/busy/en/done/addr/data=%b exp 10000000000",
               {start_ready, busy, wr_en, done, wr_addr, wr_data});
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (n_done !== d0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d exp 0", n_done - d0); end
    sweep({5'd7, 5'd3}, 10'd0, 1'b0, 1'b0);
    n_cmp++;
    if (cap_lat !== LAT) begin n_bad++; $display("FAIL rst_resweep_latency: got %0d exp %0d", cap_lat, LAT); end
    n_cmp++;
    if ({cap_addr[0], cap_addr[31]} !== {5'd0, 5'd31}) begin
      n_bad++;
      $display("FAIL rst_resweep_addr: got %0d..%0d exp 0..31", cap_addr[0], cap_addr[31]);
    end
    n_cmp++;
    if ({cap_data[3], cap_data[7], cap_data[10]} !== 6'b011000) begin
      n_bad++;
      $display("FAIL rst_resweep_data: got %b exp 011000", {cap_data[3], cap_data[7], cap_data[10]});
    end
    n_cmp++;
    if (cap_done_pos !== 1) begin n_bad++; $display("FAIL rst_resweep_done_pos: got %0d exp 1", cap_done_pos); end
  endtask
  initial begin
    test_reset();
    test_exact();
    test_mask();
    test_back_to_back();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
